pipe_hazard_ctrl: RTL

Pipeline control unit that drives the stage-register enables, bubbles and flushes of the 5-stage MIPS pipeline. It decides each cycle whether the ID/EX register loads a real instruction, loads a bubble, or holds. It also decides whether IF/ID and EX/MEM are flushed and whether the PC advances. It sits beside the decode stage and observes the ID, EX and MEM stage fields. A 3-state FSM handles data-memory wait and post-branch recovery. Saturating counters record stall and flush activity.

---
 rtl/pipe_hazard_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard control unit.
// master = pipeline side (drives stage fields), slave = control unit (drives enables).
interface pipe_hazard_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_rt_used;
    logic             EX_memread;
    logic [4:0]       EX_Rt;
    logic             MEM_memread;
    logic             MEM_memwrite;
    logic             mem_ready;
    logic             MEM_branch_taken;

    logic             pc_write;
    logic             pc_src_branch;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             EX_MEM_flush;
    logic             pipe_write;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_Rs, ID_Rt, ID_rt_used, EX_memread, EX_Rt,
        output MEM_memread, MEM_memwrite, mem_ready, MEM_branch_taken,
        input  pc_write, pc_src_branch, IF_ID_write, IF_ID_flush,
        input  ID_EX_bubble, EX_MEM_flush, pipe_write, hz_state,
        input  stall_count, flush_count
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_rt_used, EX_memread, EX_Rt,
        input  MEM_memread, MEM_memwrite, mem_ready, MEM_branch_taken,
        output pc_write, pc_src_branch, IF_ID_write, IF_ID_flush,
        output ID_EX_bubble, EX_MEM_flush, pipe_write, hz_state,
        output stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage MIPS pipeline: load-use stall, memory-wait freeze,
// taken-branch flush, with saturating stall/flush activity counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_hazard_if.slave bus
);
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_busy;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;

    logic w_pc_write;
    logic w_pc_src_branch;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_ex_mem_flush;
    logic w_pipe_write;

    always_comb begin
        w_mem_busy = (bus.MEM_memread | bus.MEM_memwrite) & ~bus.mem_ready;
        w_load_use = bus.EX_memread & (bus.EX_Rt != 5'd0) &
                     ((bus.EX_Rt == bus.ID_Rs) | (bus.ID_rt_used & (bus.EX_Rt == bus.ID_Rt)));
    end

    always_comb begin
        w_pc_write      = 1'b1;
        w_pc_src_branch = 1'b0;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_flush  = 1'b0;
        w_pipe_write    = 1'b1;
        w_stall_inc     = 1'b0;
        w_flush_inc     = 1'b0;
        w_state_next    = StRun;

        if (rst) begin
            // Drain the pipeline with bubbles while the PC is held.
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_ex_mem_flush = 1'b1;
        end else if (w_mem_busy) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_pipe_write  = 1'b0;
            w_stall_inc   = 1'b1;
            w_state_next  = StMemWait;
        end else if (r_state != StFlush) begin
            // In FLUSH the ID and MEM fields belong to squashed slots, so they are ignored.
            if (bus.MEM_branch_taken) begin
                w_pc_src_branch = 1'b1;
                w_if_id_flush   = 1'b1;
                w_id_ex_bubble  = 1'b1;
                w_ex_mem_flush  = 1'b1;
                w_flush_inc     = 1'b1;
                w_state_next    = StFlush;
            end else if (w_load_use) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
                w_stall_inc    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StRun;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_write      = w_pc_write;
    assign bus.pc_src_branch = w_pc_src_branch;
    assign bus.IF_ID_write   = w_if_id_write;
    assign bus.IF_ID_flush   = w_if_id_flush;
    assign bus.ID_EX_bubble  = w_id_ex_bubble;
    assign bus.EX_MEM_flush  = w_ex_mem_flush;
    assign bus.pipe_write    = w_pipe_write;
    assign bus.hz_state      = r_state;
    assign bus.stall_count   = r_stall_cnt;
    assign bus.flush_count   = r_flush_cnt;
endmodule
